// File: rtl/bram_w30_d1024_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_w30_d1024_dp_pkg
// Brief    : Default geometry for the 30 x 1024 true dual-port block RAM,
//            plus the field widths of the tables it stores (for reference
//            by users packing words into the 30-bit data path).
// Revision : 1.0 - initial release
// ============================================================================
package bram_w30_d1024_dp_pkg;

  localparam int BRAM_DATA_W = 30;
  localparam int BRAM_ADDR_W = 10;
  localparam int BRAM_DEPTH  = 1 << BRAM_ADDR_W;

  // Variable-state table word: {value, level}, zero-extended to 30 bits.
  localparam int VS_VALUE_W = 3;
  localparam int VS_LVL_W   = 16;

  // Level-state table word: {dcd_bin, has_bkt}, zero-extended to 30 bits.
  localparam int LS_BIN_W = 10;
  localparam int LS_BKT_W = 1;

endpackage : bram_w30_d1024_dp_pkg
`default_nettype wire

// File: rtl/bram_w30_d1024_dp_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_w30_d1024_dp_if
// Brief    : Port bundle for the true dual-port RAM. The master drives
//            addresses, write enables and write data; the slave (the RAM)
//            returns the registered read data of both ports.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_w30_d1024_dp_if
  import bram_w30_d1024_dp_pkg::*;
#(
  parameter int DATA_WIDTH = BRAM_DATA_W,
  parameter int ADDR_WIDTH = BRAM_ADDR_W
);

  // Port A
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;

  // Port B
  logic                  web;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dinb;
  logic [DATA_WIDTH-1:0] doutb;

  modport master (
    output wea, addra, dina,
    output web, addrb, dinb,
    input  douta, doutb
  );

  modport slave (
    input  wea, addra, dina,
    input  web, addrb, dinb,
    output douta, doutb
  );

endinterface : bram_w30_d1024_dp_if
`default_nettype wire

// File: rtl/bram_w30_d1024_dp.sv
`default_nettype none
// ============================================================================
// Module   : bram_w30_d1024_dp
// Brief    : True dual-port block RAM, 30 bits x 1024 words, single clock,
//            read-first on both ports, one-cycle registered read. On a
//            same-address write/write collision port B wins. rst clears
//            only the output registers (asynchronously); the array itself
//            has no reset so it maps onto a block RAM primitive.
// Revision : 1.0 - initial release
// ============================================================================
module bram_w30_d1024_dp
  import bram_w30_d1024_dp_pkg::*;
#(
  parameter int DATA_WIDTH = BRAM_DATA_W,
  parameter int ADDR_WIDTH = BRAM_ADDR_W,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             rst,
  bram_w30_d1024_dp_if.slave    bus
);

  // Storage array; power-up content is all zeros. No reset on purpose.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] douta_q;
  logic [DATA_WIDTH-1:0] doutb_q;

  // Array writes; port B is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (bus.wea) mem[bus.addra] <= bus.dina;
    if (bus.web) mem[bus.addrb] <= bus.dinb;
  end

  // Port A read register: samples the pre-write word (read-first), async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) douta_q <= '0;
    else     douta_q <= mem[bus.addra];
  end

  // Port B read register: samples the pre-write word (read-first), async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) doutb_q <= '0;
    else     doutb_q <= mem[bus.addrb];
  end

  assign bus.douta = douta_q;
  assign bus.doutb = doutb_q;

endmodule : bram_w30_d1024_dp
`default_nettype wire

// File: tb/tb_bram_w30_d1024_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_w30_d1024_dp
// Brief    : Directed scoreboard bench for the 30 x 1024 dual-port RAM.
//            Each stimulus cycle pushes the hand-computed expected outputs
//            of both ports; a monitor pops one entry after every rising
//            edge and compares the registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_w30_d1024_dp;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bram_w30_d1024_dp_if #(.DATA_WIDTH(30), .ADDR_WIDTH(10)) bus ();

  bram_w30_d1024_dp #(
    .DATA_WIDTH (30),
    .ADDR_WIDTH (10),
    .DEPTH      (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        chk_a;
    logic [29:0] exp_a;
    logic        chk_b;
    logic [29:0] exp_b;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Debug dump of a range of the array, address and binary word.
  task automatic display(input int istart, input int iend);
    for (int i = istart; i <= iend; i++)
      $display("mem[%0d] = %b", i, dut.mem[i]);
  endtask

  // One access cycle: drive both ports at the falling edge, queue expectations.
  task automatic cyc(input logic wa, input logic [9:0] aa, input logic [29:0] da,
                     input logic wb, input logic [9:0] ab, input logic [29:0] db,
                     input logic ca, input logic [29:0] ea,
                     input logic cb, input logic [29:0] eb);
    exp_t e;
    @(negedge clk);
    bus.wea = wa; bus.addra = aa; bus.dina = da;
    bus.web = wb; bus.addrb = ab; bus.dinb = db;
    e.chk_a = ca; e.exp_a = ea; e.chk_b = cb; e.exp_b = eb;
    q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk_a) check("douta", bus.douta, e.exp_a);
      if (e.chk_b) check("doutb", bus.doutb, e.exp_b);
    end
  end

  initial begin
    bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
    bus.web = 1'b0; bus.addrb = '0; bus.dinb = '0;

    // Outputs held at zero across edges while in reset.
    @(posedge clk); #1;
    check("reset_douta", bus.douta, 30'h0);
    check("reset_doutb", bus.doutb, 30'h0);
    @(negedge clk);
    rst = 1'b0;

    //   wa  addra  dina           wb  addrb  dinb           chkA expA          chkB expB
    cyc(1, 10'd5,    30'h2AAAAAAA, 0, 10'd6,    30'h0,        1, 30'h0,        1, 30'h0);        // A writes 5; addr 6 unwritten
    cyc(0, 10'd5,    30'h0,        1, 10'd1023, 30'h00001234, 1, 30'h2AAAAAAA, 1, 30'h0);        // A reads back; B writes 1023
    cyc(0, 10'd1023, 30'h0,        0, 10'd5,    30'h0,        1, 30'h00001234, 1, 30'h2AAAAAAA); // cross-port reads
    cyc(1, 10'd10,   30'h7,        0, 10'd6,    30'h0,        1, 30'h0,        1, 30'h0);        // mem[10] = 7
    cyc(1, 10'd10,   30'h9,        0, 10'd10,   30'h0,        1, 30'h7,        1, 30'h7);        // read-first, both ports
    cyc(0, 10'd10,   30'h0,        0, 10'd10,   30'h0,        1, 30'h9,        1, 30'h9);        // new word visible
    cyc(1, 10'd20,   30'h1,        1, 10'd20,   30'h2,        1, 30'h0,        1, 30'h0);        // write/write collision
    cyc(0, 10'd20,   30'h0,        0, 10'd20,   30'h0,        1, 30'h2,        1, 30'h2);        // port B won
    cyc(1, 10'd0,    30'h3FFFFFFF, 0, 10'd1023, 30'h0,        1, 30'h0,        1, 30'h00001234);
    cyc(0, 10'd0,    30'h0,        1, 10'd1023, 30'h15555555, 1, 30'h3FFFFFFF, 1, 30'h00001234);
    cyc(0, 10'd0,    30'h0,        0, 10'd1023, 30'h0,        1, 30'h3FFFFFFF, 1, 30'h15555555);

    // Asynchronous clear of nonzero outputs, before any further edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_douta", bus.douta, 30'h0);
    check("async_rst_doutb", bus.doutb, 30'h0);

    // Writes accepted during reset while outputs stay zero.
    cyc(1, 10'd30,   30'h0ABCDEF0, 0, 10'd0,    30'h0,        1, 30'h0,        1, 30'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 10'd0,    30'h0,        0, 10'd30,   30'h0,        1, 30'h3FFFFFFF, 1, 30'h0ABCDEF0); // survives reset
    cyc(0, 10'd6,    30'h0,        0, 10'd5,    30'h0,        1, 30'h0,        1, 30'h2AAAAAAA);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    display(0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bram_w30_d1024_dp
`default_nettype wire
